// File: rtl/sev_seg_pkg.sv
// Shared types and constants for the seven-segment scan block:
// FSM state encoding, active-low glyph table and all-off drive values.
package sev_seg_pkg;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a}; 10..15 render as A b C d E F
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/sev_seg_decoder.sv
// Combinational digit-to-cathode decoder: glyph lookup, decimal point,
// and a blank override that forces every segment off.
module sev_seg_decoder
  import sev_seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] cathodes
);

  always_comb begin
    cathodes = SEG_OFF;
    if (!blank) cathodes = {~dp, GLYPH[digit]};
  end

endmodule

// File: rtl/sev_seg_scan.sv
// Four-digit common-anode display scanner: per-frame snapshot of the digits,
// all-off gap before each digit, optional leading-zero blanking.
module sev_seg_scan
  import sev_seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] THOUSANDS,
  input  logic [3:0] HUNDREDS,
  input  logic [3:0] TENS,
  input  logic [3:0] ONES,
  input  logic [3:0] DP_EN,
  input  logic       LZB,
  output logic [7:0] CATHODES,
  output logic [3:0] ANODES,
  output logic       FRAME_SYNC
);

  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] D_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      idx, idx_nxt;
  logic            load, fs_nxt, fs_q;
  logic [15:0]     snap;
  logic [3:0]      dp_snap;
  logic            lzb_snap;

  logic [3:0]      cur_digit;
  logic            cur_dp;
  logic [3:0]      zero;
  logic            lz_blank;
  logic            off;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= GAP;
      cnt      <= '0;
      idx      <= '0;
      fs_q     <= 1'b0;
      snap     <= '0;
      dp_snap  <= '0;
      lzb_snap <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      fs_q  <= fs_nxt;
      if (load) begin
        snap     <= {THOUSANDS, HUNDREDS, TENS, ONES};
        dp_snap  <= DP_EN;
        lzb_snap <= LZB;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    load      = 1'b0;
    fs_nxt    = 1'b0;
    unique case (state)
      GAP: begin
        if (cnt == B_LAST) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
          // Frame boundary: capture inputs as digit 0 is about to light
          if (idx == 2'd0) begin
            load   = 1'b1;
            fs_nxt = 1'b1;
          end
        end
      end
      SHOW: begin
        if (cnt == D_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
        end
      end
      default: state_nxt = GAP;
    endcase
  end

  always_comb begin
    for (int unsigned n = 0; n < 4; n++) zero[n] = (snap[4*n +: 4] == 4'd0);
    cur_digit = snap[{idx, 2'b00} +: 4];
    cur_dp    = dp_snap[idx];
    // A digit is a leading zero when it and every digit to its left are zero
    unique case (idx)
      2'd1:    lz_blank = lzb_snap & zero[1] & zero[2] & zero[3];
      2'd2:    lz_blank = lzb_snap & zero[2] & zero[3];
      2'd3:    lz_blank = lzb_snap & zero[3];
      default: lz_blank = 1'b0;
    endcase
    off        = (state == GAP) | lz_blank;
    ANODES     = off ? AN_OFF : ~(4'b0001 << idx);
    FRAME_SYNC = fs_q;
  end

  sev_seg_decoder u_dec (
    .digit    (cur_digit),
    .dp       (cur_dp),
    .blank    (off),
    .cathodes (CATHODES)
  );

endmodule
